load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Memory stage directly downstream of the execute-stage ALU: takes the ALU result as an
//  effective address (or as a pass-through result), drives a single-outstanding data-bus
//  request for loads/stores, aligns/sign-extends load data, and hands a result to writeback.
//  Back-pressures execute via in_ready_o while a memory access is in flight.
// PARAMETERS
//  XLEN       32  datapath / address width
//  RD_W        5  destination register index width
// PORTS
//  clk_i          in   1     core clock
//  rst_i          in   1     asynchronous, active-high reset
//  in_valid_i     in   1     execute presents an instruction this cycle
//  in_ready_o     out  1     unit accepts the instruction (transfer = valid & ready)
//  alu_result_i   in   XLEN  ALU output: effective address, or final result if no mem op
//  store_data_i   in   XLEN  rs2 value for stores
//  mem_op_i       in   2     MEM_OP_NONE / MEM_OP_LOAD / MEM_OP_STORE
//  mem_size_i     in   2     MEM_SIZE_B / MEM_SIZE_H / MEM_SIZE_W
//  mem_unsigned_i in   1     1 = zero-extend load (LBU/LHU)
//  rd_i           in   RD_W  destination register
//  rd_we_i        in   1     instruction writes rd
//  mem_req_o      out  1     bus request, held until granted
//  mem_we_o       out  1     1 = write
//  mem_addr_o     out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
//  mem_be_o       out  4     byte enables
//  mem_wdata_o    out  XLEN  store data replicated into byte lanes
//  mem_gnt_i      in   1     bus accepted request this cycle
//  mem_rvalid_i   in   1     response (read data or write ack) this cycle
//  mem_rdata_i    in   XLEN  read data, valid with mem_rvalid_i
//  wb_valid_o     out  1     one-cycle pulse: result for writeback
//  wb_rd_o        out  RD_W  destination register
//  wb_we_o        out  1     write rd (0 for stores, for rd_we_i=0, and for any rd=0)
//  wb_data_o      out  XLEN  result
//  misalign_o     out  1     one-cycle pulse: misaligned access, no bus request issued
// BEHAVIOUR
//  Reset: state IDLE; mem_req_o, wb_valid_o, wb_we_o, misalign_o = 0; all data outputs 0.
//  FSM IDLE -> REQ -> RESP -> IDLE. in_ready_o = (state == IDLE), combinational.
//  IDLE, transfer, mem_op NONE: next cycle wb_valid_o=1, wb_data_o=alu_result_i (latency 1).
//  IDLE, transfer, misaligned (H with addr[0]=1, W with addr[1:0]!=0): next cycle misalign_o=1,
//   wb_valid_o=1 with wb_we_o=0; no bus request; stay IDLE.
//  IDLE, transfer, aligned LOAD/STORE: register addr/size/sign/rd/wdata; go REQ.
//  REQ: mem_req_o=1 with stable addr/we/be/wdata until mem_gnt_i; on gnt go RESP.
//  RESP: mem_req_o=0; wait mem_rvalid_i (earliest the cycle after gnt); rvalid in REQ
//   is ignored. On rvalid: wb_valid_o=1 next cycle with aligned data (loads), wb_we_o=0
//   (stores); return IDLE. Minimum load/store latency: 3 cycles accept -> wb_valid_o.
//  Byte enables: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111.
//  Write data: B -> {4{d[7:0]}}; H -> {2{d[15:0]}}; W -> d.
//  Load align: shift rdata right by 8*addr[1:0], then sign- or zero-extend from 8/16 bits.
//  in_valid_i while not IDLE is not accepted; execute must hold its inputs stable.
//  wb_valid_o/misalign_o are single-cycle pulses; no writeback back-pressure.
//  Reset mid-access: return to IDLE, drop mem_req_o immediately; a late rvalid is ignored.
//  mem_size_i = 2'b11 is treated as W.
// STRUCTURE
//  Shared header control_signals.vh: MEM_OP_NONE=0, MEM_OP_LOAD=1, MEM_OP_STORE=2;
//   MEM_SIZE_B=0, MEM_SIZE_H=1, MEM_SIZE_W=2; LSU state encodings local to this module.
//  Sub-module lsu_align (combinational): byte enables, store lane replication,
//   load shift and sign/zero extension; shared by store and load paths.
// TESTING
//  NONE op, alu_result=0x1234_5678, rd=5 -> wb_valid next cycle, wb_data=0x1234_5678, we=1.
//  LB addr 0x103, rdata 0x80FF_FF7F, gnt same cycle, rvalid +1 -> wb_data=0xFFFF_FF80;
//   LBU same -> 0x0000_0080; mem_addr_o=0x100, be=4'b1000.
//  SH addr 0x202, data 0xABCD_1234 -> be=4'b1100, wdata=0x1234_1234, we=1, wb_we_o=0.
//  LW addr 0x301 -> misalign_o pulse, mem_req_o never asserted, in_ready_o stays 1.
//  SW with gnt delayed 4 cycles -> mem_req_o and address held stable, in_ready_o=0 throughout.
//  rst_i asserted in RESP -> outputs 0 at once; subsequent rvalid produces no wb_valid_o.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
//   Shared control encodings for the memory stage: memory operation and access
//   size codes driven by decode/execute, plus the alignment rule used to reject
//   accesses before they reach the data bus.
//   No ports (package).
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

  // Memory operation carried alongside the ALU result
  localparam logic [1:0] MEM_OP_NONE  = 2'd0;
  localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [1:0] MEM_OP_STORE = 2'd2;

  // Access size; the unused code 2'b11 behaves as a word everywhere
  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  // Halfwords must sit on an even byte, words on a word boundary
  function automatic logic isMisaligned(input logic [1:0] size,
                                        input logic [1:0] addrLow);
    logic bad;
    case (size)
      MEM_SIZE_B: bad = 1'b0;
      MEM_SIZE_H: bad = addrLow[0];
      default:    bad = (addrLow != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
//   Combinational byte-lane steering shared by the store and load paths of the
//   load/store unit.
//   Ports:
//     size_i        access size (B/H/W, 2'b11 treated as W)
//     offset_i      byte offset within the word (addr[1:0])
//     unsigned_i    1 = zero-extend loaded byte/halfword
//     store_data_i  raw rs2 value
//     be_o          byte enables for the bus
//     wdata_o       store data replicated into every byte lane
//     load_data_i   raw bus read data
//     load_result_o load data shifted down and sign/zero extended
// ---------------------------------------------------------------------------
module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size_i,
  input  logic [1:0]      offset_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  input  logic [XLEN-1:0] load_data_i,
  output logic [XLEN-1:0] load_result_o
);

  logic [XLEN-1:0] shifted;

  // Bring the addressed byte/halfword down to bit 0 before extension
  assign shifted = load_data_i >> {offset_i, 3'b000};

  // Replicating store data into all lanes lets the byte enables alone pick
  // the destination bytes, so no store-side shifter is needed
  always_comb begin
    case (size_i)
      MEM_SIZE_B: begin
        be_o          = 4'b0001 << offset_i;
        wdata_o       = {(XLEN/8){store_data_i[7:0]}};
        load_result_o = unsigned_i ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                   : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      MEM_SIZE_H: begin
        be_o          = 4'b0011 << offset_i;
        wdata_o       = {(XLEN/16){store_data_i[15:0]}};
        load_result_o = unsigned_i ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                   : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be_o          = 4'b1111;
        wdata_o       = store_data_i;
        load_result_o = shifted;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Memory stage after the execute ALU. Non-memory instructions pass their ALU
//   result to writeback one cycle after acceptance; loads/stores issue one
//   outstanding bus request and stall execute until the response returns.
//   Ports:
//     clk_i, rst_i                 clock, async active-high reset
//     in_valid_i / in_ready_o      handshake with execute
//     alu_result_i, store_data_i   address/result and store data
//     mem_op_i, mem_size_i,
//     mem_unsigned_i               access description
//     rd_i, rd_we_i                destination register
//     mem_req_o .. mem_wdata_o     data-bus request (held until mem_gnt_i)
//     mem_gnt_i, mem_rvalid_i,
//     mem_rdata_i                  data-bus grant and response
//     wb_valid_o .. wb_data_o      single-cycle writeback result
//     misalign_o                   pulse for a rejected misaligned access
// ---------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [1:0]      mem_op_i,
  input  logic [1:0]      mem_size_i,
  input  logic            mem_unsigned_i,
  input  logic [RD_W-1:0] rd_i,
  input  logic            rd_we_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            wb_valid_o,
  output logic [RD_W-1:0] wb_rd_o,
  output logic            wb_we_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            misalign_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] storeData_q, storeData_d;
  logic [1:0]      size_q, size_d;
  logic            unsigned_q, unsigned_d;
  logic            storeOp_q, storeOp_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            rdWe_q, rdWe_d;
  logic            wbValid_q, wbValid_d;
  logic [RD_W-1:0] wbRd_q, wbRd_d;
  logic            wbWe_q, wbWe_d;
  logic [XLEN-1:0] wbData_q, wbData_d;
  logic            misalign_q, misalign_d;

  logic            accept;
  logic            isMemOp;
  logic            reqActive;
  logic [3:0]      alignBe;
  logic [XLEN-1:0] alignWdata;
  logic [XLEN-1:0] loadResult;

  assign accept    = in_valid_i && (state_q == ST_IDLE);
  assign isMemOp   = (mem_op_i == MEM_OP_LOAD) || (mem_op_i == MEM_OP_STORE);
  assign reqActive = (state_q == ST_REQ);

  // Both store steering and load extension work from the latched access, so
  // one aligner serves the request and the response phases
  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .size_i        (size_q),
    .offset_i      (addr_q[1:0]),
    .unsigned_i    (unsigned_q),
    .store_data_i  (storeData_q),
    .be_o          (alignBe),
    .wdata_o       (alignWdata),
    .load_data_i   (mem_rdata_i),
    .load_result_o (loadResult)
  );

  // Bus outputs are driven only while requesting so that idle/reset values
  // are zero rather than leftovers of the previous access
  assign in_ready_o  = (state_q == ST_IDLE);
  assign mem_req_o   = reqActive;
  assign mem_we_o    = reqActive && storeOp_q;
  assign mem_addr_o  = reqActive ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem_be_o    = reqActive ? alignBe : 4'b0000;
  assign mem_wdata_o = reqActive ? alignWdata : '0;

  assign wb_valid_o  = wbValid_q;
  assign wb_rd_o     = wbRd_q;
  assign wb_we_o     = wbWe_q;
  assign wb_data_o   = wbData_q;
  assign misalign_o  = misalign_q;

  // Next-state: pulses default low, access context holds between phases.
  // Writes to x0 are suppressed here so writeback never has to check rd.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    storeData_d = storeData_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    storeOp_d   = storeOp_q;
    rd_d        = rd_q;
    rdWe_d      = rdWe_q;
    wbValid_d   = 1'b0;
    wbRd_d      = wbRd_q;
    wbWe_d      = wbWe_q;
    wbData_d    = wbData_q;
    misalign_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!isMemOp) begin
            wbValid_d = 1'b1;
            wbRd_d    = rd_i;
            wbWe_d    = rd_we_i && (rd_i != '0);
            wbData_d  = alu_result_i;
          end else if (isMisaligned(mem_size_i, alu_result_i[1:0])) begin
            wbValid_d  = 1'b1;
            misalign_d = 1'b1;
            wbRd_d     = rd_i;
            wbWe_d     = 1'b0;
            wbData_d   = alu_result_i;
          end else begin
            addr_d      = alu_result_i;
            storeData_d = store_data_i;
            size_d      = mem_size_i;
            unsigned_d  = mem_unsigned_i;
            storeOp_d   = (mem_op_i == MEM_OP_STORE);
            rd_d        = rd_i;
            rdWe_d      = rd_we_i;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_rvalid_i) begin
          wbValid_d = 1'b1;
          wbRd_d    = rd_q;
          wbWe_d    = !storeOp_q && rdWe_q && (rd_q != '0);
          if (!storeOp_q) begin
            wbData_d = loadResult;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      storeData_q <= '0;
      size_q      <= MEM_SIZE_B;
      unsigned_q  <= 1'b0;
      storeOp_q   <= 1'b0;
      rd_q        <= '0;
      rdWe_q      <= 1'b0;
      wbValid_q   <= 1'b0;
      wbRd_q      <= '0;
      wbWe_q      <= 1'b0;
      wbData_q    <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      storeData_q <= storeData_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      storeOp_q   <= storeOp_d;
      rd_q        <= rd_d;
      rdWe_q      <= rdWe_d;
      wbValid_q   <= wbValid_d;
      wbRd_q      <= wbRd_d;
      wbWe_q      <= wbWe_d;
      wbData_q    <= wbData_d;
      misalign_q  <= misalign_d;
    end
  end

endmodule
